pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 3: number of post-ID control stages (stage 0 = EX, stage NSTAGE-1 = last); legal range 1..8.
REQ-002 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu (and madd when enabled); legal range 1..63.
REQ-003 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu; legal range 1..63.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 Instr_ID  in  32  instruction in ID.
REQ-007 valid_ID  in  1  Instr_ID holds a real instruction.
REQ-008 flush  in  1  kill the ID instruction (bubble into stage 0).
REQ-009 stall_ext  in  1  downstream freeze of all stages.
REQ-010 ctrl_pipe  out  NSTAGE*21  packed 21-bit control words, stage 0 at LSBs; word = WDCtrl3, ALUCtrl5, ALUBCtrl1, DM_WE2, GRFWE1, EXTCtrl1, DMEXTCtrl3, MDCCtrl3, c0_WE1, start1 (MSB to LSB).
REQ-011 RI_pipe  out  NSTAGE  per-stage reserved-instruction flag.
REQ-012 RI_ID  out  1  combinational: valid_ID and Instr_ID not a supported opcode.
REQ-013 stall_ID  out  1  combinational: ID must hold this cycle.
REQ-014 busy  out  1  registered: multiply/divide unit occupied.

Function
REQ-015 Decode SHALL be combinational from Instr_ID; supported set: lb lbu lh lhu lw sb sh sw, all R/I ALU ops, beq bne blez bgtz bltz bgez j jal jalr jr, mult multu div divu mfhi mflo mthi mtlo, mfc0 mtc0 eret.
REQ-016 Bubble SHALL be an all-zero control word with RI flag 0.
REQ-017 Stage-0 load value, priority high to low: flush -> bubble; stall_ext -> hold; stall_ID or !valid_ID -> bubble; RI_ID -> all-zero word with RI flag 1; else decoded word.
REQ-018 Stages 1..NSTAGE-1 SHALL shift from stage k-1 when stall_ext=0 and hold when stall_ext=1 (flush does not affect them).
REQ-019 Latency: a decoded word appears at stage k exactly k+1 unstalled cycles after its ID cycle.
REQ-020 stall_ID SHALL be 1 when the ID instruction is a muldiv compute/read/write op and (busy=1 or stage 0 start=1); else 0.
REQ-021 Busy counter (6 bits): on a cycle where a mult/multu/div/divu enters stage 0 with its decoded word, load MULT_CYCLES or DIV_CYCLES; otherwise decrement if nonzero; busy = counter!=0.
REQ-022 Counter SHALL decrement during stall_ext; a flushed or stalled muldiv op SHALL NOT load it.
REQ-023 start=1 only for mult/multu/div/divu (and madd when enabled); GRFWE=0 for stores, branches except jal/jalr, j, jr, mult-class, mthi/mtlo, mtc0, eret.

Reset
REQ-024 reset SHALL zero all ctrl_pipe words, RI_pipe and busy counter in the same edge; busy=0 and stall_ID reflects only stage-0 start (now 0) next cycle.
REQ-025 reset mid-operation SHALL abandon any in-flight muldiv busy count.

Configuration
REQ-026 Macro MADD_EN: when defined, madd (SPECIAL2, funct 000000) decodes as a mult-class op with MDCCtrl=5, start=1, busy load MULT_CYCLES; when undefined, madd SHALL raise RI_ID.

Structure
REQ-027 Package pipe_ctrl_pkg SHALL hold opcode/funct constants, control-word field offsets/widths, WDCtrl/ALUCtrl/MDCCtrl encodings, CW_W=21.
REQ-028 One combinational sub-module instr_decode (Instr -> 21-bit word, RI, class flags) SHALL be instantiated once.

Verification
REQ-029 addu then lw, no stalls -> addu word in stage 0 at cycle 1, stage 2 at cycle 3; lw word GRFWE=1, DM_WE=0 one cycle behind.
REQ-030 div (DIV_CYCLES=10) then mflo back-to-back -> stall_ID=1 for 10 cycles, mflo enters stage 0 on cycle 11, busy falls at cycle 11.
REQ-031 Instr_ID=32'hFC000000 valid -> RI_ID=1, stage-0 word 0, RI_pipe[0]=1 next cycle, propagates to RI_pipe[2].
REQ-032 flush=1 and stall_ext=1 same cycle with mult in ID -> stage 0 bubble, stages 1..2 held, busy stays 0.
REQ-033 mult issued, reset asserted 2 cycles later -> next cycle busy=0, all ctrl_pipe=0, following mfhi not stalled.
REQ-034 madd with MADD_EN undefined -> RI_ID=1; with MADD_EN defined -> start=1, busy for 5 cycles.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline control slice.
//   - MIPS opcode / funct / COP0 rs constants for the supported subset
//   - 21-bit control word layout (cw_t) with field encodings
//   - CW_W: control word width
// Control word layout, MSB to LSB:
//   wd[20:18] alu[17:13] alub[12] dm_we[11:10] grfwe[9] ext[8]
//   dmext[7:5] mdc[4:2] c0_we[1] start[0]
package pipe_ctrl_pkg;

    localparam int CW_W = 21;

    // Field offsets / widths inside the control word
    localparam int WD_O    = 18;  localparam int WD_W    = 3;
    localparam int ALU_O   = 13;  localparam int ALU_W   = 5;
    localparam int ALUB_O  = 12;
    localparam int DMWE_O  = 10;  localparam int DMWE_W  = 2;
    localparam int GRFWE_O = 9;
    localparam int EXT_O   = 8;
    localparam int DMEXT_O = 5;   localparam int DMEXT_W = 3;
    localparam int MDC_O   = 2;   localparam int MDC_W   = 3;
    localparam int C0WE_O  = 1;
    localparam int START_O = 0;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_REGIMM   = 6'b000001;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_BLEZ     = 6'b000110;
    localparam logic [5:0] OP_BGTZ     = 6'b000111;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_ADDIU    = 6'b001001;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_SLTIU    = 6'b001011;
    localparam logic [5:0] OP_ANDI     = 6'b001100;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_XORI     = 6'b001110;
    localparam logic [5:0] OP_LUI      = 6'b001111;
    localparam logic [5:0] OP_COP0     = 6'b010000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LB       = 6'b100000;
    localparam logic [5:0] OP_LH       = 6'b100001;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_LBU      = 6'b100100;
    localparam logic [5:0] OP_LHU      = 6'b100101;
    localparam logic [5:0] OP_SB       = 6'b101000;
    localparam logic [5:0] OP_SH       = 6'b101001;
    localparam logic [5:0] OP_SW       = 6'b101011;

    // SPECIAL funct codes
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_JALR  = 6'b001001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F2_MADD = 6'b000000;

    // COP0 rs field and the single legal eret encoding
    localparam logic [4:0]  RS_MF = 5'b00000;
    localparam logic [4:0]  RS_MT = 5'b00100;
    localparam logic [31:0] ERET  = 32'h4200_0018;

    // Register write data source
    typedef enum logic [2:0] {
        WD_ALU = 3'd0, WD_DM = 3'd1, WD_PC8 = 3'd2,
        WD_HI  = 3'd3, WD_LO = 3'd4, WD_CP0 = 3'd5
    } wd_e;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_AND  = 5'd2,  ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,  ALU_NOR  = 5'd5,  ALU_SLT  = 5'd6,  ALU_SLTU = 5'd7,
        ALU_SLL  = 5'd8,  ALU_SRL  = 5'd9,  ALU_SRA  = 5'd10, ALU_SLLV = 5'd11,
        ALU_SRLV = 5'd12, ALU_SRAV = 5'd13, ALU_LUI  = 5'd14
    } alu_e;

    // Multiply/divide unit command
    typedef enum logic [2:0] {
        MDC_NONE = 3'd0, MDC_MULT = 3'd1, MDC_MULTU = 3'd2, MDC_DIV  = 3'd3,
        MDC_DIVU = 3'd4, MDC_MADD = 3'd5, MDC_MTHI  = 3'd6, MDC_MTLO = 3'd7
    } mdc_e;

    // dm_we: 0 none, 1 byte, 2 half, 3 word
    // dmext: 0 word, 1 lb, 2 lbu, 3 lh, 4 lhu
    typedef struct packed {
        wd_e        wd;
        alu_e       alu;
        logic       alub;
        logic [1:0] dm_we;
        logic       grfwe;
        logic       ext;
        logic [2:0] dmext;
        mdc_e       mdc;
        logic       c0_we;
        logic       start;
    } cw_t;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// instr_decode: purely combinational decoder, Instr -> 21-bit control word.
//   instr   in  32  instruction to decode
//   cw      out     control word (all zero when ri=1)
//   ri      out     instruction is outside the supported set
//   md_use  out     instruction uses the mult/div unit (compute, hi/lo read or write)
//   md_div  out     instruction is div/divu (selects the longer busy count)
// Configuration macro: MADD_EN -- decode SPECIAL2 madd as a mult-class op.
module instr_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output cw_t         cw,
    output logic        ri,
    output logic        md_use,
    output logic        md_div
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign funct = instr[5:0];

    always_comb begin
        cw     = '0;
        ri     = 1'b0;
        md_use = 1'b0;
        md_div = 1'b0;
        case (op)
            OP_SPECIAL: begin
                cw.grfwe = 1'b1;
                case (funct)
                    F_SLL:          cw.alu = ALU_SLL;
                    F_SRL:          cw.alu = ALU_SRL;
                    F_SRA:          cw.alu = ALU_SRA;
                    F_SLLV:         cw.alu = ALU_SLLV;
                    F_SRLV:         cw.alu = ALU_SRLV;
                    F_SRAV:         cw.alu = ALU_SRAV;
                    F_ADD, F_ADDU:  cw.alu = ALU_ADD;
                    F_SUB, F_SUBU:  cw.alu = ALU_SUB;
                    F_AND:          cw.alu = ALU_AND;
                    F_OR:           cw.alu = ALU_OR;
                    F_XOR:          cw.alu = ALU_XOR;
                    F_NOR:          cw.alu = ALU_NOR;
                    F_SLT:          cw.alu = ALU_SLT;
                    F_SLTU:         cw.alu = ALU_SLTU;
                    F_JR:           cw.grfwe = 1'b0;
                    F_JALR:         cw.wd = WD_PC8;
                    F_MFHI: begin cw.wd = WD_HI; md_use = 1'b1; end
                    F_MFLO: begin cw.wd = WD_LO; md_use = 1'b1; end
                    F_MTHI: begin cw.grfwe = 1'b0; cw.mdc = MDC_MTHI; md_use = 1'b1; end
                    F_MTLO: begin cw.grfwe = 1'b0; cw.mdc = MDC_MTLO; md_use = 1'b1; end
                    F_MULT: begin
                        cw.grfwe = 1'b0; cw.mdc = MDC_MULT; cw.start = 1'b1; md_use = 1'b1;
                    end
                    F_MULTU: begin
                        cw.grfwe = 1'b0; cw.mdc = MDC_MULTU; cw.start = 1'b1; md_use = 1'b1;
                    end
                    F_DIV: begin
                        cw.grfwe = 1'b0; cw.mdc = MDC_DIV; cw.start = 1'b1;
                        md_use = 1'b1; md_div = 1'b1;
                    end
                    F_DIVU: begin
                        cw.grfwe = 1'b0; cw.mdc = MDC_DIVU; cw.start = 1'b1;
                        md_use = 1'b1; md_div = 1'b1;
                    end
                    default: ri = 1'b1;
                endcase
            end
            // Only bltz (rt=0) and bgez (rt=1) live under REGIMM here.
            OP_REGIMM: ri = (rt > 5'd1);
            OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ;
            OP_JAL: begin cw.wd = WD_PC8; cw.grfwe = 1'b1; end
            OP_ADDI, OP_ADDIU: begin
                cw.alu = ALU_ADD; cw.alub = 1'b1; cw.ext = 1'b1; cw.grfwe = 1'b1;
            end
            OP_SLTI: begin
                cw.alu = ALU_SLT; cw.alub = 1'b1; cw.ext = 1'b1; cw.grfwe = 1'b1;
            end
            OP_SLTIU: begin
                cw.alu = ALU_SLTU; cw.alub = 1'b1; cw.ext = 1'b1; cw.grfwe = 1'b1;
            end
            OP_ANDI: begin cw.alu = ALU_AND; cw.alub = 1'b1; cw.grfwe = 1'b1; end
            OP_ORI:  begin cw.alu = ALU_OR;  cw.alub = 1'b1; cw.grfwe = 1'b1; end
            OP_XORI: begin cw.alu = ALU_XOR; cw.alub = 1'b1; cw.grfwe = 1'b1; end
            OP_LUI:  begin cw.alu = ALU_LUI; cw.alub = 1'b1; cw.grfwe = 1'b1; end
            OP_COP0: begin
                if (rs == RS_MF) begin
                    cw.wd = WD_CP0; cw.grfwe = 1'b1;
                end else if (rs == RS_MT) begin
                    cw.c0_we = 1'b1;
                end else if (instr != ERET) begin
                    ri = 1'b1;
                end
            end
            OP_SPECIAL2: begin
`ifdef MADD_EN
                if (funct == F2_MADD) begin
                    cw.mdc = MDC_MADD; cw.start = 1'b1; md_use = 1'b1;
                end else begin
                    ri = 1'b1;
                end
`else
                ri = 1'b1;
`endif
            end
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
                cw.wd = WD_DM; cw.alu = ALU_ADD; cw.alub = 1'b1; cw.ext = 1'b1;
                cw.grfwe = 1'b1;
                case (op)
                    OP_LB:   cw.dmext = 3'd1;
                    OP_LBU:  cw.dmext = 3'd2;
                    OP_LH:   cw.dmext = 3'd3;
                    OP_LHU:  cw.dmext = 3'd4;
                    default: cw.dmext = 3'd0;
                endcase
            end
            OP_SB, OP_SH, OP_SW: begin
                cw.alu = ALU_ADD; cw.alub = 1'b1; cw.ext = 1'b1;
                case (op)
                    OP_SB:   cw.dm_we = 2'd1;
                    OP_SH:   cw.dm_we = 2'd2;
                    default: cw.dm_we = 2'd3;
                endcase
            end
            default: ri = 1'b1;
        endcase

        // A reserved instruction carries no control at all.
        if (ri) begin
            cw     = '0;
            md_use = 1'b0;
            md_div = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: post-ID control pipeline with mult/div busy tracking.
// Parameters: NSTAGE (1..8), MULT_CYCLES (1..63), DIV_CYCLES (1..63).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   Instr_ID        instruction in ID;  valid_ID  it is real
//   flush           bubble into stage 0; stall_ext freeze all stages
//   ctrl_pipe       NSTAGE packed 21-bit control words, stage 0 at LSBs
//   RI_pipe         per-stage reserved-instruction flag
//   RI_ID           valid ID instruction is unsupported (combinational)
//   stall_ID        ID must hold this cycle (combinational)
//   busy            mult/div unit occupied (registered counter != 0)
// Configuration macro: MADD_EN (handled inside instr_decode).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE      = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            Instr_ID,
    input  logic                   valid_ID,
    input  logic                   flush,
    input  logic                   stall_ext,
    output logic [NSTAGE*CW_W-1:0] ctrl_pipe,
    output logic [NSTAGE-1:0]      RI_pipe,
    output logic                   RI_ID,
    output logic                   stall_ID,
    output logic                   busy
);

    cw_t  dec_cw;
    logic dec_ri;
    logic dec_md_use;
    logic dec_md_div;

    instr_decode u_decode (
        .instr  (Instr_ID),
        .cw     (dec_cw),
        .ri     (dec_ri),
        .md_use (dec_md_use),
        .md_div (dec_md_div)
    );

    cw_t              cw_q [NSTAGE];
    cw_t              cw_d [NSTAGE];
    logic [NSTAGE-1:0] ri_q;
    logic [NSTAGE-1:0] ri_d;
    logic [5:0]        cnt_q;
    logic [5:0]        cnt_d;
    logic              cnt_load;

    assign RI_ID = valid_ID & dec_ri;
    assign busy  = (cnt_q != 6'd0);
    // Stage-0 start covers the cycle a freshly issued op sits in EX; the
    // counter already loaded on that edge, so both terms agree in practice.
    assign stall_ID = valid_ID & dec_md_use & (busy | cw_q[0].start);

    always_comb begin
        cw_d[0] = cw_q[0];
        ri_d[0] = ri_q[0];
        if (flush) begin
            cw_d[0] = '0;
            ri_d[0] = 1'b0;
        end else if (stall_ext) begin
            cw_d[0] = cw_q[0];
            ri_d[0] = ri_q[0];
        end else if (stall_ID || !valid_ID) begin
            cw_d[0] = '0;
            ri_d[0] = 1'b0;
        end else if (dec_ri) begin
            cw_d[0] = '0;
            ri_d[0] = 1'b1;
        end else begin
            cw_d[0] = dec_cw;
            ri_d[0] = 1'b0;
        end

        // Later stages ignore flush; only the external freeze holds them.
        for (int k = 1; k < NSTAGE; k++) begin
            cw_d[k] = stall_ext ? cw_q[k] : cw_q[k-1];
            ri_d[k] = stall_ext ? ri_q[k] : ri_q[k-1];
        end

        // Load only when the decoded start word actually lands in stage 0.
        cnt_load = !flush && !stall_ext && valid_ID && !stall_ID && !dec_ri && dec_cw.start;
        if (cnt_load) begin
            cnt_d = dec_md_div ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
        end else if (cnt_q != 6'd0) begin
            cnt_d = cnt_q - 6'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                cw_q[k] <= '0;
            end
            ri_q  <= '0;
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                cw_q[k] <= cw_d[k];
            end
            ri_q  <= ri_d;
            cnt_q <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_pack
            assign ctrl_pipe[gi*CW_W +: CW_W] = cw_q[gi];
        end
    endgenerate

    assign RI_pipe = ri_q;

endmodule
